button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the debounced, clk-synchronous level from the `debounce` stage and turns it into single-cycle user-interface events.
- Events are: press, release, tap (short press), long-press, and auto-repeat while held.
- Sits directly downstream of `debounce`, with one instance per button.
- Its event pulses drive the control FSMs, so those FSMs never do edge detection or hold timing themselves.

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles the button must stay pressed before `long_pulse` fires. Legal values are >= 2.
- REPEAT_CYCLES, default 10_000_000: cycles between successive `repeat_pulse` outputs once held. Legal values are >= 2.
- CNT_W (localparam): $clog2 of max(HOLD_CYCLES, REPEAT_CYCLES). This is the width of the single shared counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  debounced button level from `debounce`; 1 = pressed; already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- tap_pulse  output  1  one-cycle pulse on a release that happens before the long-press threshold.
- long_pulse  output  1  one-cycle pulse when the hold threshold is reached.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held past the threshold.
- held  output  1  level; 1 while in state HELD.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset: state = IDLE, cnt = 0, all outputs = 0. Reset asserted mid-press aborts silently: no release or tap pulse is generated.
- Outputs are registered, so every pulse appears in the cycle after the edge that decides it and lasts exactly one cycle.
- FSM states: IDLE, PRESSED, HELD. Transitions are evaluated at each rising clk edge:
  - IDLE, in = 1: go to PRESSED, cnt <= 0, press_pulse <= 1.
  - IDLE, in = 0: stay in IDLE.
  - PRESSED, in = 0: go to IDLE, cnt <= 0, release_pulse <= 1, tap_pulse <= 1.
  - PRESSED, in = 1, cnt == HOLD_CYCLES-1: go to HELD, cnt <= 0, long_pulse <= 1.
  - PRESSED, in = 1, otherwise: cnt <= cnt + 1.
  - HELD, in = 0: go to IDLE, cnt <= 0, release_pulse <= 1 (no tap_pulse).
  - HELD, in = 1, cnt == REPEAT_CYCLES-1: cnt <= 0, repeat_pulse <= 1.
  - HELD, in = 1, otherwise: cnt <= cnt + 1.
- Resulting timing:
  - long_pulse rises exactly HOLD_CYCLES cycles after press_pulse.
  - The first repeat_pulse rises REPEAT_CYCLES cycles after long_pulse, then repeats every REPEAT_CYCLES cycles.
- held = (state == HELD). It rises in the same cycle as long_pulse and falls in the same cycle as release_pulse.
- Simultaneous events: release wins.
  - If in = 0 on the edge where cnt == HOLD_CYCLES-1, it is a tap; no long_pulse.
  - If in = 0 on the edge where cnt == REPEAT_CYCLES-1, there is no repeat_pulse.
- At most one of press_pulse, release_pulse, long_pulse, repeat_pulse is high in any cycle. tap_pulse is only ever high together with release_pulse.
- `in` high when reset deasserts: press_pulse fires after the first edge. No suppression is applied.
- The counter never wraps. It is cleared on every state change and bounded by the compare value.
- A press lasting 1 cycle (in high for one edge) is legal: press_pulse, then release_pulse + tap_pulse in the next cycle.

Decomposition:
- Shared package `ui_pkg`: the state enum (IDLE / PRESSED / HELD) and default timing constants (HOLD_CYCLES_DEF, REPEAT_CYCLES_DEF) at the 100 MHz board clock.
- No sub-module is needed. This is a single FSM plus one counter and registered outputs.
- The top level instantiates `debounce` then `button_event`, one pair per button.

Test Plan:
All scenarios use HOLD_CYCLES = 8 and REPEAT_CYCLES = 4.
1. Reset while in = 0, hold for 10 cycles -> all outputs 0, held = 0.
2. in high for 3 cycles, then low -> press_pulse 1 cycle, then release_pulse + tap_pulse together 3 cycles later; no long_pulse.
3. in high for 20 cycles -> press_pulse at T, long_pulse and held rise at T+8, repeat_pulse at T+12, T+16, T+20. On release: release_pulse, no tap_pulse, held falls.
4. in falls on exactly the threshold edge (high for 8 edges) -> release_pulse + tap_pulse, no long_pulse, held stays 0.
5. Assert reset asynchronously mid-HELD -> outputs 0 immediately, no release_pulse. in still 1 at deassert -> press_pulse after the first edge.
6. in toggles 1, 0, 1, 0 on consecutive edges -> press_pulse, release+tap, press_pulse, release+tap in successive cycles; never two event pulses in the same cycle.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared UI types: button FSM states and default hold/repeat timing
// for the 100 MHz board clock.
package ui_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_e;

   localparam int HOLD_CYCLES_DEF   = 50_000_000;
   localparam int REPEAT_CYCLES_DEF = 10_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into registered single-cycle events:
// press, release, tap, long-press and auto-repeat, plus a held level.
module button_event
   import ui_pkg::*;
#(
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic press_pulse,
   output logic release_pulse,
   output logic tap_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   btn_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic press_q, press_d;
   logic rel_q, rel_d;
   logic tap_q, tap_d;
   logic long_q, long_d;
   logic rep_q, rep_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      tap_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            // release is checked first so it wins over the threshold
            if (!in) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
               tap_d   = 1'b1;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!in) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end else if (cnt_q == REP_LAST) begin
               cnt_d = '0;
               rep_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         tap_q   <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         tap_q   <= tap_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign tap_pulse     = tap_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = rep_q;
   assign held          = (state_q == HELD);

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// Output vector order: {press, release, tap, long, repeat, held}.
module tb_button_event;

   logic clk;
   logic reset;
   logic in_s;
   logic press_pulse, release_pulse, tap_pulse;
   logic long_pulse, repeat_pulse, held;

   int total = 0;
   int bad   = 0;

   button_event #(
      .HOLD_CYCLES  (8),
      .REPEAT_CYCLES(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in           (in_s),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .tap_pulse    (tap_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [5:0] NONE  = 6'b000000;
   localparam logic [5:0] PRS   = 6'b100000;
   localparam logic [5:0] RTAP  = 6'b011000;
   localparam logic [5:0] REL   = 6'b010000;
   localparam logic [5:0] LNG   = 6'b000101;
   localparam logic [5:0] HLD   = 6'b000001;
   localparam logic [5:0] RPT   = 6'b000011;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {press_pulse, release_pulse, tap_pulse,
             long_pulse, repeat_pulse, held};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] e;
      reset = 1'b1;
      in_s  = 1'b0;

      // 1: reset held with in low
      for (int i = 0; i < 10; i++) begin
         step();
         chk("reset_idle", NONE);
      end
      reset = 1'b0;
      step();
      chk("post_reset", NONE);

      // 2: short press of 3 edges -> tap
      in_s = 1'b1;
      step();
      chk("tap_press", PRS);
      step();
      chk("tap_hold1", NONE);
      step();
      chk("tap_hold2", NONE);
      in_s = 1'b0;
      step();
      chk("tap_release", RTAP);
      step();
      chk("tap_quiet", NONE);

      // 3: long hold with repeats
      in_s = 1'b1;
      step();
      chk("long_press", PRS);
      for (int k = 1; k <= 20; k++) begin
         if (k < 8)                 e = NONE;
         else if (k == 8)           e = LNG;
         else if ((k - 8) % 4 == 0) e = RPT;
         else                       e = HLD;
         step();
         chk($sformatf("long_k%0d", k), e);
      end
      in_s = 1'b0;
      step();
      chk("long_release", REL);
      step();
      chk("long_quiet", NONE);

      // 4: release on the threshold edge is a tap
      in_s = 1'b1;
      step();
      chk("thr_press", PRS);
      for (int k = 1; k <= 7; k++) begin
         step();
         chk($sformatf("thr_k%0d", k), NONE);
      end
      in_s = 1'b0;
      step();
      chk("thr_release", RTAP);
      step();
      chk("thr_quiet", NONE);

      // 5: async reset while held
      in_s = 1'b1;
      step();
      chk("rst_press", PRS);
      for (int k = 1; k <= 8; k++) step();
      chk("rst_long", LNG);
      step();
      step();
      chk("rst_held", HLD);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async", NONE);
      step();
      chk("rst_hold1", NONE);
      step();
      chk("rst_hold2", NONE);
      reset = 1'b0;
      step();
      chk("rst_repress", PRS);
      in_s = 1'b0;
      step();
      chk("rst_tap", RTAP);
      step();
      chk("rst_quiet", NONE);

      // 6: toggling every edge
      in_s = 1'b1;
      step();
      chk("tog_p1", PRS);
      in_s = 1'b0;
      step();
      chk("tog_r1", RTAP);
      in_s = 1'b1;
      step();
      chk("tog_p2", PRS);
      in_s = 1'b0;
      step();
      chk("tog_r2", RTAP);
      step();
      chk("tog_quiet", NONE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
